// File: rtl/rr_priority_arbiter_pkg.sv
// Shared types, mode constants and helpers for the round-robin / fixed-priority arbiter.
// Supports up to MAX_N requesters.
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  localparam int unsigned MAX_N = 32;

  // A one-hot word has exactly one set bit, so OR-ing the indices of set bits yields its index.
  // An all-zero word yields 0, which is also the idle value of gnt_idx.
  function automatic int unsigned onehot_to_idx(input logic [MAX_N-1:0] oh);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < MAX_N; i++) begin
      if (oh[i]) idx = idx | i;
    end
    return idx;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_priority_arbiter_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface rr_priority_arbiter_if #(
  parameter int N = 4
);
  import arb_pkg::*;

  localparam int IDXW = idx_width(N);

  logic [N-1:0]    req;
  logic [N-1:0]    gnt;
  logic            gnt_valid;
  logic [IDXW-1:0] gnt_idx;

  modport master (output req, input gnt, input gnt_valid, input gnt_idx);
  modport slave  (input req, output gnt, output gnt_valid, output gnt_idx);

endinterface

// File: rtl/rr_priority_arbiter_prio_pick.sv
// Combinational find-first-set: keeps only the lowest set bit of vec.
module prio_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] vec,
  output logic [N-1:0] first
);

  // Carry chain: a bit survives only if no lower bit was set.
  always_comb begin
    logic seen;
    // NOTE: every variable gets a value before any branch or loop, so no latch can be inferred.
    first = '0;
    seen  = 1'b0;
    for (int i = 0; i < N; i++) begin
      first[i] = vec[i] & ~seen;
      seen     = seen | vec[i];
    end
  end

endmodule

// File: rtl/rr_priority_arbiter.sv
// N-way arbiter: fixed-priority or round-robin selection, registered one-hot grant,
// grant locking while the owner keeps req high, and preemption after MAX_HOLD contended cycles.
module rr_priority_arbiter
  import arb_pkg::*;
#(
  parameter  int N        = 4,
  parameter  int MODE     = MODE_RR,
  parameter  int MAX_HOLD = 4,
  localparam int IDXW     = idx_width(N)
) (
  input logic                  clk,
  input logic                  rst_n,
  rr_priority_arbiter_if.slave bus
);

  localparam int              HCW       = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HCW-1:0]  HOLD_LAST = HCW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

  state_t          state;
  logic [N-1:0]    gnt_q;
  logic            gnt_valid_q;
  logic [IDXW-1:0] gnt_idx_q;
  logic [IDXW-1:0] ptr;
  logic [HCW-1:0]  hold_cnt;

  logic [N-1:0]    req;
  logic [N-1:0]    cand;
  logic [N-1:0]    rr_mask;
  logic [N-1:0]    masked_pick;
  logic [N-1:0]    full_pick;
  logic [N-1:0]    win;
  logic [IDXW-1:0] win_idx;
  logic [IDXW-1:0] next_ptr;
  logic            owner_req;
  logic            contended;
  logic            hold_expired;
  logic            take;
  logic            drop;

  assign req = bus.req;

  // Decide what happens at the next edge and which requesters compete.
  always_comb begin
    owner_req    = |(req & gnt_q);
    contended    = |(req & ~gnt_q);
    hold_expired = (MAX_HOLD > 0) && (hold_cnt == HOLD_LAST);
    take         = 1'b0;
    drop         = 1'b0;
    cand         = req;
    case (state)
      IDLE: take = |req;
      GRANT: begin
        if (!owner_req) begin
          take = |req;
          drop = ~(|req);
        end else if (hold_expired && contended) begin
          take = 1'b1;
          cand = req & ~gnt_q;
        end
      end
      default: ;
    endcase
  end

  // Round-robin: search from ptr upward first, then wrap to the lowest index.
  // In fixed mode ptr stays 0, so the mask passes everything through.
  always_comb begin
    rr_mask = '0;
    for (int i = 0; i < N; i++) begin
      rr_mask[i] = (i >= int'(ptr));
    end
  end

  prio_pick #(.N(N)) u_pick_masked (
    .vec   (cand & rr_mask),
    .first (masked_pick)
  );

  prio_pick #(.N(N)) u_pick_full (
    .vec   (cand),
    .first (full_pick)
  );

  assign win      = (|masked_pick) ? masked_pick : full_pick;
  assign win_idx  = IDXW'(onehot_to_idx(MAX_N'(win)));
  assign next_ptr = (win_idx == IDXW'(N - 1)) ? '0 : win_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      gnt_idx_q   <= '0;
      ptr         <= '0;
      hold_cnt    <= '0;
    end else if (take) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      state       <= GRANT;
      gnt_q       <= win;
      gnt_valid_q <= 1'b1;
      gnt_idx_q   <= win_idx;
      hold_cnt    <= '0;
      if (MODE == MODE_RR) ptr <= next_ptr;
    end else if (drop) begin
      state       <= IDLE;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      gnt_idx_q   <= '0;
      hold_cnt    <= '0;
    end else if (state == GRANT && hold_cnt != HOLD_LAST) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.gnt_idx   = gnt_idx_q;

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// Random and directed stimulus on three arbiter configurations, checked against an
// owner/held-count/pointer reference model.
module tb_rr_priority_arbiter;
  import arb_pkg::*;

  localparam int N  = 4;
  localparam int ND = 3;
  localparam int MODE_OF [ND] = '{MODE_RR, MODE_FIXED, MODE_RR};
  localparam int HOLD_OF [ND] = '{4, 4, 0};

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic [N-1:0] req_v   [ND];
  logic [N-1:0] gnt_o   [ND];
  logic         valid_o [ND];
  logic [1:0]   idx_o   [ND];

  int errors = 0;
  int checks = 0;

  int           m_owner [ND];
  int           m_held  [ND];
  int           m_ptr   [ND];
  logic [N-1:0] prev_req[ND];

  always #5 clk = ~clk;

  rr_priority_arbiter_if #(.N(N)) if_rr ();
  rr_priority_arbiter_if #(.N(N)) if_fx ();
  rr_priority_arbiter_if #(.N(N)) if_nh ();

  rr_priority_arbiter #(.N(N), .MODE(MODE_RR),    .MAX_HOLD(4)) dut_rr (.clk(clk), .rst_n(rst_n), .bus(if_rr.slave));
  rr_priority_arbiter #(.N(N), .MODE(MODE_FIXED), .MAX_HOLD(4)) dut_fx (.clk(clk), .rst_n(rst_n), .bus(if_fx.slave));
  rr_priority_arbiter #(.N(N), .MODE(MODE_RR),    .MAX_HOLD(0)) dut_nh (.clk(clk), .rst_n(rst_n), .bus(if_nh.slave));

  assign if_rr.req = req_v[0];
  assign if_fx.req = req_v[1];
  assign if_nh.req = req_v[2];
  assign gnt_o[0] = if_rr.gnt;  assign valid_o[0] = if_rr.gnt_valid;  assign idx_o[0] = if_rr.gnt_idx;
  assign gnt_o[1] = if_fx.gnt;  assign valid_o[1] = if_fx.gnt_valid;  assign idx_o[1] = if_fx.gnt_idx;
  assign gnt_o[2] = if_nh.gnt;  assign valid_o[2] = if_nh.gnt_valid;  assign idx_o[2] = if_nh.gnt_idx;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Next requester by the arbitration rule: lowest index, or first at/after ptr with wrap.
  function automatic int pick(input int d, input logic [N-1:0] set);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (MODE_OF[d] == MODE_FIXED) ? k : (m_ptr[d] + k) % N;
      if (set[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_grant(input int d, input int i);
    m_owner[d] = i;
    m_held[d]  = 1;
    if (MODE_OF[d] == MODE_RR) m_ptr[d] = (i + 1) % N;
  endtask

  // m_held counts the cycles the current owner has had the grant so far.
  task automatic model_step(input int d, input logic [N-1:0] r);
    int           own;
    logic [N-1:0] others;
    own    = m_owner[d];
    others = r;
    if (own >= 0) others[own] = 1'b0;
    if (own < 0 || !r[own]) begin
      if (r != 0) model_grant(d, pick(d, r));
      else        m_owner[d] = -1;
    end else if (HOLD_OF[d] > 0 && m_held[d] >= HOLD_OF[d] && others != 0) begin
      model_grant(d, pick(d, others));
    end else begin
      m_held[d]++;
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      m_owner[d]  = -1;
      m_held[d]   = 0;
      m_ptr[d]    = 0;
      prev_req[d] = '0;
    end
  endtask

  function automatic int idx_of(input logic [N-1:0] g);
    for (int i = 0; i < N; i++) if (g[i]) return i;
    return 0;
  endfunction

  task automatic check_all(input string tag);
    for (int d = 0; d < ND; d++) begin
      logic [N-1:0] exp_g;
      exp_g = '0;
      if (m_owner[d] >= 0) exp_g[m_owner[d]] = 1'b1;
      check($sformatf("%s.%0d.gnt", tag, d), 32'(gnt_o[d]), 32'(exp_g));
      check($sformatf("%s.%0d.valid", tag, d), 32'(valid_o[d]), 32'(m_owner[d] >= 0));
      check($sformatf("%s.%0d.idx", tag, d), 32'(idx_o[d]), (m_owner[d] >= 0) ? m_owner[d] : 0);
      check($sformatf("%s.%0d.onehot0", tag, d), 32'($onehot0(gnt_o[d])), 32'd1);
      check($sformatf("%s.%0d.valid_or", tag, d), 32'(valid_o[d]), 32'(|gnt_o[d]));
      check($sformatf("%s.%0d.idx_match", tag, d), 32'(idx_o[d]), idx_of(gnt_o[d]));
      check($sformatf("%s.%0d.subset", tag, d), 32'(gnt_o[d] & ~prev_req[d]), 32'd0);
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    for (int d = 0; d < ND; d++) begin
      model_step(d, req_v[d]);
      prev_req[d] = req_v[d];
    end
    #1;
    check_all(tag);
  endtask

  // Called 1 time unit after an edge: asserts reset between edges and releases it before the next one.
  task automatic mid_reset(input logic [N-1:0] r0, input logic [N-1:0] r1, input logic [N-1:0] r2);
    #3 rst_n = 1'b0;
    #1;
    for (int d = 0; d < ND; d++) begin
      check($sformatf("rst_async.%0d.gnt", d), 32'(gnt_o[d]), 32'd0);
      check($sformatf("rst_async.%0d.valid", d), 32'(valid_o[d]), 32'd0);
      check($sformatf("rst_async.%0d.idx", d), 32'(idx_o[d]), 32'd0);
    end
    model_reset();
    req_v[0] = r0;
    req_v[1] = r1;
    req_v[2] = r2;
    #2 rst_n = 1'b1;
  endtask

  initial begin
    for (int d = 0; d < ND; d++) req_v[d] = '0;
    model_reset();
    #1 rst_n = 1'b0;
    #2;
    for (int d = 0; d < ND; d++) begin
      check($sformatf("reset.%0d.gnt", d), 32'(gnt_o[d]), 32'd0);
      check($sformatf("reset.%0d.valid", d), 32'(valid_o[d]), 32'd0);
      check($sformatf("reset.%0d.idx", d), 32'(idx_o[d]), 32'd0);
    end
    #9 rst_n = 1'b1;

    // All requesting: rotation in RR, 0/1 ping-pong in fixed mode, lock forever with no preemption.
    req_v[0] = 4'b1111;
    req_v[1] = 4'b1111;
    req_v[2] = 4'b0011;
    for (int c = 0; c < 20; c++) begin
      step("all_req");
      check("rr_rotate", 32'(gnt_o[0]), 32'(1 << ((c / 4) % 4)));
      check("fixed_pingpong", 32'(gnt_o[1]), ((c / 4) % 2 == 1) ? 32'd2 : 32'd1);
      check("no_preempt", 32'(gnt_o[2]), 32'd1);
    end
    for (int d = 0; d < ND; d++) req_v[d] = '0;
    step("idle");

    // Single requester for three cycles, then release.
    req_v[0] = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      step("single");
      check("single_gnt", 32'(gnt_o[0]), 32'b0100);
    end
    req_v[0] = 4'b0000;
    step("single_drop");
    check("single_drop_gnt", 32'(gnt_o[0]), 32'd0);
    check("single_drop_valid", 32'(valid_o[0]), 32'd0);

    // Pointer wrap after a grant to index 2, then handover to requester 0.
    req_v[0] = 4'b1001;
    step("wrap");
    check("wrap_gnt", 32'(gnt_o[0]), 32'b1000);
    req_v[0] = 4'b0001;
    step("wrap_release");
    check("wrap_release_gnt", 32'(gnt_o[0]), 32'b0001);

    // Direct handover without an idle bubble.
    step("owner_hold");
    req_v[0] = 4'b0100;
    req_v[1] = 4'b0100;
    step("handover");
    check("handover_gnt", 32'(gnt_o[0]), 32'b0100);
    check("handover_fixed_gnt", 32'(gnt_o[1]), 32'b0100);

    // Reset while requester 1 owns the grant; pointer restarts at 0.
    req_v[0] = 4'b0010;
    step("pre_reset");
    check("pre_reset_gnt", 32'(gnt_o[0]), 32'b0010);
    mid_reset(4'b1100, 4'b1100, 4'b1100);
    step("post_reset");
    check("post_reset_gnt", 32'(gnt_o[0]), 32'b0100);

    // Random traffic with sticky requests and occasional asynchronous resets.
    for (int c = 0; c < 400; c++) begin
      for (int d = 0; d < ND; d++) begin
        if ($urandom_range(0, 3) == 0) req_v[d] = 4'($urandom_range(0, 15));
      end
      if (c % 97 == 96) mid_reset(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
